// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory handshake, redirect/stall controls and the decode-side output register.
interface fetch_stage_if #(
  parameter int PC_W = 64
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic            PCSrc;
  logic [PC_W-1:0] PCBranch;
  logic            stall;
  logic            valid_D;
  logic [31:0]     instr_D;
  logic [PC_W-1:0] pc_D;
  logic [10:0]     Op_D;

  modport master (
    output imem_req, imem_addr, valid_D, instr_D, pc_D, Op_D,
    input  imem_valid, imem_rdata, PCSrc, PCBranch, stall
  );

  modport slave (
    input  imem_req, imem_addr, valid_D, instr_D, pc_D, Op_D,
    output imem_valid, imem_rdata, PCSrc, PCBranch, stall
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, 1-entry skid buffer, branch redirect with squash.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt, a saturating count of instructions delivered to decode.
module fetch_stage #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } slot_t;

  state_t          state;
  logic            req_q;
  logic [PC_W-1:0] addr_q;
  logic [PC_W-1:0] tgt_q;
  slot_t           skid_q;
  slot_t           out_q;
  logic            out_vld_q;

  logic            resp;
  logic            room;
  logic            load_out;
  logic [PC_W-1:0] addr_inc;
  logic [PC_W-1:0] branch_pc;

  // A response only counts while our own request is up.
  assign resp      = bus.imem_valid & req_q;
  assign room      = ~out_vld_q | ~bus.stall;
  assign addr_inc  = addr_q + PC_W'(4);
  assign branch_pc = bus.PCBranch & ~PC_W'(3);

  always_comb begin
    load_out = 1'b0;
    if (!bus.PCSrc) begin
      if (state == S_FETCH && resp && room) load_out = 1'b1;
      if (state == S_HOLD && !bus.stall)    load_out = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      tgt_q     <= RESET_PC;
      skid_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      req_q <= 1'b1;
      case (state)
        S_FETCH: begin
          if (bus.PCSrc) begin
            out_vld_q <= 1'b0;
            // No request in flight (just out of reset) or it lands now: retarget directly.
            if (resp || !req_q) begin
              addr_q <= branch_pc;
            end else begin
              tgt_q <= branch_pc;
              state <= S_DISCARD;
            end
          end else if (resp) begin
            addr_q <= addr_inc;
            if (room) begin
              out_q     <= '{instr: bus.imem_rdata, pc: addr_q};
              out_vld_q <= 1'b1;
            end else begin
              skid_q <= '{instr: bus.imem_rdata, pc: addr_q};
              state  <= S_HOLD;
              req_q  <= 1'b0;
            end
          end else if (!bus.stall) begin
            out_vld_q <= 1'b0;
          end
        end

        S_HOLD: begin
          if (bus.PCSrc) begin
            out_vld_q <= 1'b0;
            skid_q    <= '0;
            addr_q    <= branch_pc;
            state     <= S_FETCH;
          end else if (!bus.stall) begin
            out_q     <= skid_q;
            out_vld_q <= 1'b1;
            state     <= S_FETCH;
          end else begin
            req_q <= 1'b0;
          end
        end

        S_DISCARD: begin
          // imem_addr stays on the squashed request until its response drains.
          if (bus.PCSrc) begin
            out_vld_q <= 1'b0;
            tgt_q     <= branch_pc;
            if (resp) begin
              addr_q <= branch_pc;
              state  <= S_FETCH;
            end
          end else begin
            if (!bus.stall) out_vld_q <= 1'b0;
            if (resp) begin
              addr_q <= tgt_q;
              state  <= S_FETCH;
            end
          end
        end

        default: begin
          state     <= S_FETCH;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.valid_D   = out_vld_q;
  assign bus.instr_D   = out_q.instr;
  assign bus.pc_D      = out_q.pc;
  assign bus.Op_D      = out_q.instr[31:21];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      perf_fetch_cnt <= '0;
    else if (load_out && perf_fetch_cnt != 32'hFFFF_FFFF)
      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
  end
`endif

  a_addr_stable: assert property (@(posedge clk)
    (reset && req_q && !bus.imem_valid) |=> (!$past(reset) || $stable(addr_q) || !reset));

  a_hold_no_req: assert property (@(posedge clk)
    (state == S_HOLD) |-> !req_q);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed corner cases, then random traffic checked against a program-order scoreboard.
module tb_fetch_stage;
  localparam int PC_W = 64;

  typedef struct {
    logic [63:0] pc;
    int          epoch;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.PC_W(PC_W)) bus ();
  fetch_stage_if #(.PC_W(PC_W)) bus2 ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf;
  logic [31:0] perf2;
`endif

  fetch_stage #(.PC_W(PC_W), .RESET_PC(64'h0)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf)
`endif
  );

  fetch_stage #(.PC_W(PC_W), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk),
    .reset(reset),
    .bus(bus2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF842_0000;
      64'h4:   return 32'hF800_0000;
      64'h8:   return 32'hB400_0000;
      64'hC:   return 32'h8B00_0000;
      default: return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
    endcase
  endfunction

  assign bus.imem_rdata  = mem_word(bus.imem_addr);
  assign bus2.imem_rdata = mem_word(bus2.imem_addr);
  assign bus2.imem_valid = 1'b1;
  assign bus2.stall      = 1'b0;
  assign bus2.PCSrc      = 1'b0;
  assign bus2.PCBranch   = '0;

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  logic [10:0] op_tbl [4];

  exp_t exp_q [$];
  int   drv_epoch = 0;
  int   mon_epoch = 0;
  logic [63:0] drv_next;
  logic mon_en = 1'b0;

  logic        p_redir = 1'b0;
  logic        p_hold = 1'b0;
  logic        p_wait = 1'b0;
  logic [63:0] p_pc, p_addr;
  logic [31:0] p_instr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whatever decode sees at the negedge is what the DUT acts on at the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t        e;
      logic [31:0] ew;
      if (p_redir) chk("redir_bubble", bus.valid_D, 1'b0);
      if (p_hold) begin
        chk("hold_vld", bus.valid_D, 1'b1);
        chk("hold_pc", bus.pc_D, p_pc);
        chk("hold_instr", bus.instr_D, p_instr);
      end
      if (p_wait && bus.imem_req) chk("addr_stable", bus.imem_addr, p_addr);
      if (bus.valid_D && !bus.stall) begin
        while (exp_q.size() > 0 && exp_q[0].epoch < mon_epoch) void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: got pc %0h expected no delivery", bus.pc_D);
        end else begin
          e  = exp_q.pop_front();
          ew = mem_word(e.pc);
          chk("sb_pc", bus.pc_D, e.pc);
          chk("sb_instr", bus.instr_D, ew);
          chk("sb_op", bus.Op_D, ew[31:21]);
          n_acc++;
        end
      end
      if (bus.PCSrc) mon_epoch++;
      p_redir = bus.PCSrc;
      p_hold  = bus.valid_D && bus.stall && !bus.PCSrc;
      p_pc    = bus.pc_D;
      p_instr = bus.instr_D;
      p_wait  = bus.imem_req && !bus.imem_valid;
      p_addr  = bus.imem_addr;
    end
  end

  initial begin
    op_tbl[0] = 11'h7C2;
    op_tbl[1] = 11'h7C0;
    op_tbl[2] = 11'h5A0;
    op_tbl[3] = 11'h458;
    bus.imem_valid = 1'b0;
    bus.stall      = 1'b0;
    bus.PCSrc      = 1'b0;
    bus.PCBranch   = '0;
    reset          = 1'b0;

    repeat (3) step();
    chk("rst_valid", bus.valid_D, 1'b0);
    chk("rst_instr", bus.instr_D, 32'h0);
    chk("rst_pc", bus.pc_D, 64'h0);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_req_wrap", bus2.imem_req, 1'b0);

    // Back-to-back fetch, no stalls
    reset = 1'b1;
    bus.imem_valid = 1'b1;
    step();
    chk("rel_req", bus.imem_req, 1'b1);
    chk("rel_addr", bus.imem_addr, 64'h0);
    chk("rel_valid", bus.valid_D, 1'b0);
    chk("wrap_addr0", bus2.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_valid", bus.valid_D, 1'b1);
      chk("seq_pc", bus.pc_D, 64'(i * 4));
      chk("seq_op", bus.Op_D, op_tbl[i]);
      if (i == 0) chk("wrap_addr1", bus2.imem_addr, 64'h0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_4", perf, 32'd4);
`endif

    // Stall parks one response in the skid buffer
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req", bus.imem_req, 1'b0);
      chk("stall_pc", bus.pc_D, 64'hC);
      chk("stall_instr", bus.instr_D, 32'h8B00_0000);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_pc", bus.pc_D, 64'h10);
    chk("unstall_instr", bus.instr_D, mem_word(64'h10));
    step();
    chk("resume_pc", bus.pc_D, 64'h14);
    chk("resume_valid", bus.valid_D, 1'b1);

    // Redirect while the request to 0x8 is outstanding
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("pre_br_addr", bus.imem_addr, 64'h8);
    bus.imem_valid = 1'b0;
    bus.PCSrc      = 1'b1;
    bus.PCBranch   = 64'h103;
    step();
    chk("br_valid", bus.valid_D, 1'b0);
    chk("br_keep_addr", bus.imem_addr, 64'h8);
    chk("br_req", bus.imem_req, 1'b1);
    bus.PCSrc      = 1'b0;
    bus.imem_valid = 1'b1;
    step();
    chk("drain_valid", bus.valid_D, 1'b0);
    chk("drain_addr", bus.imem_addr, 64'h100);
    step();
    chk("tgt_valid", bus.valid_D, 1'b1);
    chk("tgt_pc", bus.pc_D, 64'h100);

    // Redirect coinciding with a response and a stall
    bus.stall    = 1'b1;
    bus.PCSrc    = 1'b1;
    bus.PCBranch = 64'h200;
    step();
    chk("br2_valid", bus.valid_D, 1'b0);
    chk("br2_addr", bus.imem_addr, 64'h200);
    chk("br2_req", bus.imem_req, 1'b1);
    bus.PCSrc = 1'b0;
    bus.stall = 1'b0;
    step();
    chk("br2_pc", bus.pc_D, 64'h200);

    // Reset while holding a parked response
    bus.stall = 1'b1;
    step();
    chk("hold_req", bus.imem_req, 1'b0);
    reset = 1'b0;
    step();
    chk("rst2_valid", bus.valid_D, 1'b0);
    chk("rst2_instr", bus.instr_D, 32'h0);
    chk("rst2_pc", bus.pc_D, 64'h0);
    chk("rst2_op", bus.Op_D, 11'h0);
    chk("rst2_req", bus.imem_req, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_rst", perf, 32'd0);
`endif
    reset = 1'b1;
    bus.stall = 1'b0;
    step();
    chk("rel2_req", bus.imem_req, 1'b1);
    chk("rel2_addr", bus.imem_addr, 64'h0);

    // Random traffic: expected program order is pushed as it is defined, monitor consumes it
    drv_next = 64'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int          cnt;
      logic [63:0] tgt;
      bus.stall      = ($urandom % 4) == 0;
      bus.imem_valid = ($urandom % 3) != 0;
      bus.PCSrc      = ($urandom % 12) == 0;
      if (bus.PCSrc) begin
        if ($urandom % 4 == 0) tgt = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom % 256);
        else                   tgt = 64'($urandom % 4096);
        bus.PCBranch = tgt;
        drv_epoch++;
        drv_next = tgt & ~64'h3;
      end
      cnt = 0;
      foreach (exp_q[k]) if (exp_q[k].epoch == drv_epoch) cnt++;
      while (cnt < 4) begin
        exp_q.push_back('{pc: drv_next, epoch: drv_epoch});
        drv_next = drv_next + 64'd4;
        cnt++;
      end
      mon_en = 1'b1;
      step();
    end
    mon_en = 1'b0;
    chk("enough_delivered", 64'(n_acc > 100), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
